// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: start bit, N data bits LSB-first, optional even parity, stop bit.
// Each bit lasts DIV clocks and the line idles high.
module serial_frame_tx #(
  parameter int N         = 8,
  parameter int DIV       = 4,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic         s_out,
  output logic         busy,
  output logic         done
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = $clog2(N);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic [BIT_W-1:0] bit_q;
  logic [N-1:0]     shreg_q;
  logic             par_q;
  logic             s_out_q;
  logic             done_q;
  logic             tick;

  // With DIV=1 the divider is a single bit pinned at zero, so tick is always true.
  assign tick  = (div_q == DIV_LAST);
  assign div_d = tick ? '0 : div_q + DIV_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      s_out_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        div_q <= '0;
        if (din_valid) begin
          shreg_q <= din;
          par_q   <= ^din;
          state_q <= START;
          s_out_q <= 1'b0;
        end
      end else begin
        div_q <= div_d;
        if (tick) begin
          case (state_q)
            START: begin
              state_q <= DATA;
              bit_q   <= '0;
              s_out_q <= shreg_q[0];
            end
            DATA: begin
              if (bit_q == BIT_LAST) begin
                if (PARITY_EN) begin
                  state_q <= PARITY;
                  s_out_q <= par_q;
                end else begin
                  state_q <= STOP;
                  s_out_q <= 1'b1;
                end
              end else begin
                // s_out takes the next bit now, ahead of the shift landing in shreg_q.
                bit_q   <= bit_q + BIT_W'(1);
                shreg_q <= shreg_q >> 1;
                s_out_q <= shreg_q[1];
              end
            end
            PARITY: begin
              state_q <= STOP;
              s_out_q <= 1'b1;
            end
            STOP: begin
              state_q <= IDLE;
              s_out_q <= 1'b1;
              done_q  <= 1'b1;
            end
            default: begin
              state_q <= IDLE;
              s_out_q <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  assign din_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign s_out     = s_out_q;
  assign done      = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: a frame-level queue model checked every cycle, plus literal frame patterns.
// Instance A uses N=8, DIV=4 with parity; instance B uses N=8, DIV=1 without parity.
module tb_serial_frame_tx;

  localparam int  DIV_A = 4;
  localparam bit  PAR_A = 1'b1;
  localparam int  DIV_B = 1;
  localparam bit  PAR_B = 1'b0;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din_a, din_b;
  logic       dv_a, dv_b;
  logic       rdy_a, rdy_b, so_a, so_b, busy_a, busy_b, done_a, done_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_frame_tx #(.N(8), .DIV(DIV_A), .PARITY_EN(PAR_A)) u_a (
    .clk(clk), .reset(reset), .din(din_a), .din_valid(dv_a),
    .din_ready(rdy_a), .s_out(so_a), .busy(busy_a), .done(done_a)
  );

  serial_frame_tx #(.N(8), .DIV(DIV_B), .PARITY_EN(PAR_B)) u_b (
    .clk(clk), .reset(reset), .din(din_b), .din_valid(dv_b),
    .din_ready(rdy_b), .s_out(so_b), .busy(busy_b), .done(done_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Line level of bit slot `slot` in a frame: 0 start, 1..8 data LSB-first, then parity/stop.
  function automatic logic frame_bit(input logic [7:0] d, input bit par, input int slot);
    logic [7:0] t;
    if (slot == 0) return 1'b0;
    if (slot <= 8) begin
      t = d >> (slot - 1);
      return t[0];
    end
    if (par && slot == 9) return ^d;
    return 1'b1;
  endfunction

  // Each queue holds the expected line level for every remaining cycle of the current frame.
  logic qa[$];
  logic qb[$];
  logic dexp_a = 1'b0;
  logic dexp_b = 1'b0;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      qa.delete(); qb.delete();
      dexp_a = 1'b0; dexp_b = 1'b0;
    end else begin
      dexp_a = 1'b0;
      if (qa.size() != 0) begin
        void'(qa.pop_front());
        if (qa.size() == 0) dexp_a = 1'b1;
      end else if (dv_a) begin
        for (int s = 0; s < 10 + int'(PAR_A); s++)
          for (int k = 0; k < DIV_A; k++) qa.push_back(frame_bit(din_a, PAR_A, s));
      end
      dexp_b = 1'b0;
      if (qb.size() != 0) begin
        void'(qb.pop_front());
        if (qb.size() == 0) dexp_b = 1'b1;
      end else if (dv_b) begin
        for (int s = 0; s < 10 + int'(PAR_B); s++)
          for (int k = 0; k < DIV_B; k++) qb.push_back(frame_bit(din_b, PAR_B, s));
      end
    end
  end

  always @(negedge clk) begin
    chk("model_sout_a",  so_a,   (qa.size() != 0) ? int'(qa[0]) : 1);
    chk("model_busy_a",  busy_a, int'(qa.size() != 0));
    chk("model_ready_a", rdy_a,  int'(qa.size() == 0));
    chk("model_done_a",  done_a, dexp_a);
    chk("model_sout_b",  so_b,   (qb.size() != 0) ? int'(qb[0]) : 1);
    chk("model_busy_b",  busy_b, int'(qb.size() != 0));
    chk("model_ready_b", rdy_b,  int'(qb.size() == 0));
    chk("model_done_b",  done_b, dexp_b);
  end

  logic cap[0:63];
  int   cap_busy;

  task automatic capture(input int len, input bit sel);
    cap_busy = 0;
    for (int i = 0; i < len; i++) begin
      if (i > 0) @(negedge clk);
      cap[i] = sel ? so_b : so_a;
      cap_busy += sel ? int'(busy_b) : int'(busy_a);
    end
  endtask

  task automatic check_slots(input string name, input logic [10:0] bits, input int ns, input int div);
    logic [10:0] t;
    int act;
    for (int s = 0; s < ns; s++) begin
      t = bits >> s;
      act = int'(t[0]);
      for (int k = 0; k < div; k++)
        if (cap[s*div+k] !== t[0]) act = int'(cap[s*div+k]);
      chk($sformatf("%s_slot%0d", name, s), act, int'(t[0]));
    end
  endtask

  task automatic check_done_a(input string name);
    @(negedge clk);
    chk({name, "_done"},  done_a, 1);
    chk({name, "_ready"}, rdy_a,  1);
    chk({name, "_idle"},  so_a,   1);
  endtask

  int bsum;
  int dsum;

  initial begin
    reset = 1'b1;
    dv_a = 1'b0; dv_b = 1'b0;
    din_a = 8'h00; din_b = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_sout",  so_a,   1);
    chk("rst_busy",  busy_a, 0);
    chk("rst_ready", rdy_a,  1);
    chk("rst_done",  done_a, 0);
    din_a = 8'hFF; dv_a = 1'b1;
    @(negedge clk);
    chk("rst_ignores_valid", busy_a, 0);
    dv_a = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single 0xA5 frame, with a rejected 0xFF request held for 10 cycles mid-frame.
    din_a = 8'hA5; dv_a = 1'b1;
    @(negedge clk);
    dv_a = 1'b0;
    fork
      capture(44, 1'b0);
      begin
        repeat (4) @(negedge clk);
        din_a = 8'hFF; dv_a = 1'b1;
        repeat (10) begin
          @(negedge clk);
          chk("reject_ready", rdy_a, 0);
        end
        dv_a = 1'b0;
      end
    join
    check_slots("a5", 11'b1_0_10100101_0, 11, DIV_A);
    chk("a5_busy_cycles", cap_busy, 44);
    check_done_a("a5");
    bsum = 0;
    repeat (12) begin
      @(negedge clk);
      bsum += int'(busy_a);
    end
    chk("no_queued_frame", bsum, 0);

    // Back-to-back: valid held across 0xA5 then 0x0F.
    din_a = 8'hA5; dv_a = 1'b1;
    @(negedge clk);
    din_a = 8'h0F;
    for (int i = 0; i < 100 && !done_a; i++) @(negedge clk);
    chk("b2b_done_seen", done_a, 1);
    chk("b2b_gap_high",  so_a,   1);
    chk("b2b_gap_ready", rdy_a,  1);
    @(negedge clk);
    chk("b2b_second_accept", busy_a, 1);
    chk("b2b_second_start",  so_a,   0);
    dv_a = 1'b0;
    capture(44, 1'b0);
    check_slots("0f", 11'b1_0_00001111_0, 11, DIV_A);
    check_done_a("0f");

    // Asynchronous reset during the third data bit of a 0xC3 frame.
    repeat (2) @(negedge clk);
    din_a = 8'hC3; dv_a = 1'b1;
    @(negedge clk);
    dv_a = 1'b0;
    repeat (12) @(negedge clk);
    chk("pre_abort_bit", so_a, 0);
    #2 reset = 1'b1;
    #1;
    chk("abort_sout",  so_a,   1);
    chk("abort_busy",  busy_a, 0);
    chk("abort_ready", rdy_a,  1);
    chk("abort_done",  done_a, 0);
    @(negedge clk);
    reset = 1'b0;
    dsum = 0;
    repeat (5) begin
      @(negedge clk);
      dsum += int'(done_a);
    end
    chk("abort_no_done", dsum, 0);
    din_a = 8'h3C; dv_a = 1'b1;
    @(negedge clk);
    dv_a = 1'b0;
    capture(44, 1'b0);
    check_slots("3c", 11'b1_0_00111100_0, 11, DIV_A);
    check_done_a("3c");

    // Capture isolation: din changes right after the accept edge.
    repeat (2) @(negedge clk);
    din_a = 8'h55; dv_a = 1'b1;
    @(negedge clk);
    din_a = 8'hAA; dv_a = 1'b0;
    capture(44, 1'b0);
    check_slots("55", 11'b1_0_01010101_0, 11, DIV_A);
    check_done_a("55");

    // DIV=1, no parity, 0x80.
    din_b = 8'h80; dv_b = 1'b1;
    @(negedge clk);
    dv_b = 1'b0;
    capture(10, 1'b1);
    check_slots("b80", 11'b0_1_10000000_0, 10, DIV_B);
    chk("b80_busy_cycles", cap_busy, 10);
    @(negedge clk);
    chk("b80_done",  done_b, 1);
    chk("b80_idle",  busy_b, 0);
    chk("b80_ready", rdy_b,  1);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
